// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop process the
// operands LSB-first, one bit per clock, behind valid/ready handshakes.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             step;
  logic             last;
  logic             s_bit;
  logic             c_bit;

  // Full-adder cell on the current LSBs; new sum bit enters at the MSB end.
  always_comb begin
    s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
    c_bit     = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_shift = sum >> 1;
    sum_shift[WIDTH-1] = s_bit;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand shift registers, carry, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum   <= sum_shift;
      carry <= c_bit;
      cnt   <= cnt + CW'(1);
      if (last) begin
        // carry currently holds the carry into the MSB
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end
  end

endmodule
